wddl_phase_ctrl: RTL
====================

# wddl_phase_ctrl

Sequencer for a WDDL dual-rail combinational datapath built from dual-rail LUT gates. Accepts single-rail operands over a valid/ready handshake and drives the datapath rails through an explicit precharge phase (all rails 0), then an evaluate phase. It samples the dual-rail result after a fixed settle time, checks rail integrity, and returns a single-rail result with fault flags. Sits between the single-rail control/register domain and any WDDL gate network, such as an S-box or round-logic slice.

## Interface
- WIDTH, 8, operand/result width in bits (1..64)
- PRE_CYCLES, 1, precharge cycles before each evaluation (1..15)
- EVAL_CYCLES, 2, evaluate cycles allowed for the datapath to settle (1..15)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  controller can accept an operand
- in_data  in  WIDTH  single-rail operand
- dr_t  out  WIDTH  true rails to the datapath
- dr_f  out  WIDTH  false rails to the datapath
- res_t  in  WIDTH  datapath true-rail result
- res_f  in  WIDTH  datapath false-rail result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  WIDTH  single-rail result (sampled res_t)
- out_status  out  2  bit0 = evaluation rail fault; bit1 = precharge fault
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, PRECHARGE, EVAL, HOLD. All outputs are registered.
- IDLE
  - in_ready=1, dr_t=dr_f=0.
  - On in_valid: latch in_data into op_reg, load the 4-bit counter with PRE_CYCLES-1, go to PRECHARGE.
- PRECHARGE
  - dr_t=dr_f=0 and the counter decrements.
  - On the last cycle (counter==0): sample |(res_t|res_f) into pre_fault, load the counter with EVAL_CYCLES-1, go to EVAL.
- EVAL
  - dr_t=op_reg and dr_f=~op_reg for exactly EVAL_CYCLES cycles; the counter decrements.
  - On the last cycle:
    - out_data<=res_t.
    - out_status[0]<=|~(res_t^res_f): any bit with both rails 0 (incomplete) or both 1 (illegal).
    - out_status[1]<=pre_fault.
    - Go to HOLD.
- HOLD
  - dr_t=dr_f=0: precharge starts immediately after evaluation.
  - out_valid=1. out_data and out_status stay stable until out_ready.
  - On out_ready: go to IDLE.
- in_valid is ignored outside IDLE, and in_data is not sampled then.
- Faults do not alter sequencing. They are reported per result, not sticky across results.
- dr_t and dr_f are never both 1 on the same bit in any cycle.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; counter=0; op_reg=0; pre_fault=0.
  - dr_t=dr_f=0; in_ready=0 while rst_n=0, then 1 from the first clock after release.
  - out_valid=0; out_data=0; out_status=0; busy=0.
- Accept edge E0 occurs when in_valid and in_ready are both high.
- Precharge occupies cycles E0+1..E0+PRE_CYCLES.
- Rails evaluate during cycles E0+PRE_CYCLES+1..E0+PRE_CYCLES+EVAL_CYCLES.
- out_valid rises at E0+PRE_CYCLES+EVAL_CYCLES+1.
- Minimum issue interval is PRE_CYCLES+EVAL_CYCLES+2 cycles, with no bypass from HOLD to PRECHARGE.
- Simultaneous out_ready in HOLD and in_valid: go to IDLE first; the new operand is accepted on the following edge.
- Holding out_ready low holds HOLD indefinitely. Rails stay precharged throughout.
- Reset asserted mid-PRECHARGE, EVAL, or HOLD aborts the operation. No out_valid is produced for it, and rails are 0 asynchronously.
- The result is sampled from res_t/res_f combinationally at the final EVAL edge. The datapath must settle within EVAL_CYCLES-1 cycles plus one cycle of combinational delay.

## Test plan
- Reset/idle: rst_n low with in_valid=1 → all outputs 0; after release, in_ready=1 and rails stay 0.
- Inverter datapath (res_t=dr_f, res_f=dr_t), WIDTH=8, PRE=1, EVAL=2, in_data=0x3C:
  - rails 0 for 1 cycle.
  - dr_t=0x3C and dr_f=0xC3 for 2 cycles.
  - out_valid 4 cycles after E0 with out_data=0xC3 and out_status=00.
- Backpressure: out_ready held low for 5 cycles → out_data stable, rails 0, in_ready=0. Raise out_ready → IDLE next cycle, and a new operand is accepted one cycle later.
- Faults:
  - Force res_t[2]=res_f[2]=0 during EVAL → out_status=01.
  - Force res_f[0]=1 during PRECHARGE → out_status=10.
  - Next clean operation → 00.
- Reset mid-EVAL: rst_n low in the second EVAL cycle → rails 0 immediately, no out_valid. After release, operand 0xA5 completes normally with out_data=0x5A.
- Back-to-back with PRE=3, EVAL=1:
  - Issue interval is exactly 6 cycles.
  - dr_t&dr_f==0 every cycle.
  - Every EVAL window is preceded by ≥3 all-zero rail cycles.

Source files
------------

// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate sequencer for a WDDL dual-rail datapath: drives the rails
// from a single-rail operand, samples the dual-rail result and flags rail faults.
module wddl_phase_ctrl #(
  parameter int WIDTH       = 8,
  parameter int PRE_CYCLES  = 1,
  parameter int EVAL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] dr_t,
  output logic [WIDTH-1:0] dr_f,
  input  logic [WIDTH-1:0] res_t,
  input  logic [WIDTH-1:0] res_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_status,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [3:0] PRE_LOAD  = 4'(PRE_CYCLES - 1);
  localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYCLES - 1);

  // A valid WDDL bit has exactly one rail high; equal rails mean incomplete or illegal.
  function automatic logic eval_fault(input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] f);
    return |(~(t ^ f));
  endfunction

  logic [1:0]       state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [WIDTH-1:0] op_r, op_s;
  logic             pre_fault_r, pre_fault_s;
  logic             in_ready_s, out_valid_s, busy_s;
  logic [WIDTH-1:0] dr_t_s, dr_f_s, out_data_s;
  logic [1:0]       out_status_s;

  // Next-state and next-output computation; rails default to precharge (all 0).
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    op_s         = op_r;
    pre_fault_s  = pre_fault_r;
    in_ready_s   = in_ready;
    out_valid_s  = out_valid;
    out_data_s   = out_data;
    out_status_s = out_status;
    dr_t_s       = {WIDTH{1'b0}};
    dr_f_s       = {WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_s       = in_data;
          cnt_s      = PRE_LOAD;
          in_ready_s = 1'b0;
          state_s    = ST_PRE;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      ST_PRE: begin
        if (cnt_r == 4'd0) begin
          pre_fault_s = |(res_t | res_f);
          cnt_s       = EVAL_LOAD;
          dr_t_s      = op_r;
          dr_f_s      = ~op_r;
          state_s     = ST_EVAL;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_EVAL: begin
        if (cnt_r == 4'd0) begin
          out_data_s   = res_t;
          out_status_s = {pre_fault_r, eval_fault(res_t, res_f)};
          out_valid_s  = 1'b1;
          state_s      = ST_HOLD;
        end else begin
          cnt_s  = cnt_r - 4'd1;
          dr_t_s = op_r;
          dr_f_s = ~op_r;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = 4'd0;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State, datapath and registered outputs; reset forces rails to 0 immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      op_r        <= {WIDTH{1'b0}};
      pre_fault_r <= 1'b0;
      in_ready    <= 1'b0;
      dr_t        <= {WIDTH{1'b0}};
      dr_f        <= {WIDTH{1'b0}};
      out_valid   <= 1'b0;
      out_data    <= {WIDTH{1'b0}};
      out_status  <= 2'b00;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      op_r        <= op_s;
      pre_fault_r <= pre_fault_s;
      in_ready    <= in_ready_s;
      dr_t        <= dr_t_s;
      dr_f        <= dr_f_s;
      out_valid   <= out_valid_s;
      out_data    <= out_data_s;
      out_status  <= out_status_s;
      busy        <= busy_s;
    end
  end

endmodule
